// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deserialise 11-bit frames, queue good bytes (optional PS2_RX_TIMEOUT_EN).
// Latency: ps2_clk pin fall on the stop bit to ready = SYNC_STAGES+1 clk cycles.
// Backpressure: none toward the device; a good frame arriving while full is dropped and sets sticky overflow.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ps2_rx_fifo: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall_vld;
    logic                   bit_dat;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall_vld = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_dat  = dat_sync[SYNC_STAGES-1];

    logic [3:0] bit_cnt;
    logic [9:0] shreg;
    logic       frame_done;
    logic       frame_ok;
    logic       timeout_vld;

    assign frame_done = fall_vld & (bit_cnt == 4'd10);
    // shreg[0]=start, [8:1]=data, [9]=parity; the stop bit is the live sample.
    assign frame_ok   = ~shreg[0] & bit_dat & (^shreg[9:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= 4'd0;
            shreg   <= 10'd0;
        end else if (fall_vld) begin
            if (bit_cnt == 4'd10) begin
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {bit_dat, shreg[9:1]};
            end
        end else if (timeout_vld) begin
            bit_cnt <= 4'd0;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    assign timeout_vld = ~fall_vld & (bit_cnt != 4'd0) &
                         (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || fall_vld || timeout_vld || bit_cnt == 4'd0) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    assign timeout_vld = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (frame_done & ~frame_ok) | timeout_vld;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          pop_vld;
    logic          push_vld;

    assign empty    = (rptr == wptr);
    assign full     = (rptr[AW] != wptr[AW]) && (rptr[AW-1:0] == wptr[AW-1:0]);
    assign pop_vld  = ~nextdata_n & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push_vld = frame_done & frame_ok & (~full | pop_vld);

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wptr[AW-1:0]] <= shreg[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_vld) begin
                wptr <= wptr + PW'(1);
            end
            if (pop_vld) begin
                rptr <= rptr + PW'(1);
            end
            if (frame_done && frame_ok && full && !pop_vld) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ready = ~empty;
    assign data  = mem[rptr[AW-1:0]];
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frames driven at a shortened PS/2 bit period, bytes scoreboarded against a queue model.
// Pops are checked by an independent monitor; define PS2_RX_TIMEOUT_EN to also exercise the idle timeout.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int S     = 3;
    localparam int TO    = 200;
    localparam int H     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    always #10 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    logic [7:0] exp_q[$];
    logic       exp_ovf;
    int         exp_ferr  = 0;
    int         ferr_seen = 0;
    int         pops_seen = 0;
    logic [7:0] last_pop  = 8'h00;
    int         n_cmp     = 0;
    int         n_bad     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever nextdata_n is low with ready high.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_seen++;
        if (reset === 1'b0 && nextdata_n === 1'b0 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_data: got %02h, expected nothing queued", data);
            end else begin
                chk("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
            last_pop = data;
            pops_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tick(1);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            nextdata_n = 1'b0;
            tick(1);
            nextdata_n = 1'b1;
            tick(1);
        end
    endtask

    // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop. nbits<11 leaves a partial frame.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits,
                              input bit pop_at_end, output int lat);
        logic [10:0] f;
        logic        was_ready;
        f = {1'b1, ~^b, b, 1'b0};
        if (kind == 1) f[9]  = ~f[9];
        if (kind == 2) f[0]  = 1'b1;
        if (kind == 3) f[10] = 1'b0;
        was_ready = ready;
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(H);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (int k = 1; k <= H; k++) begin
                    tick(1);
                    if (pop_at_end && k == S)     nextdata_n = 1'b0;
                    if (pop_at_end && k == S + 1) nextdata_n = 1'b1;
                    if (lat < 0 && !was_ready && ready === 1'b1) lat = k;
                end
            end else begin
                tick(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(H);
        if (nbits == 11) begin
            if (kind != 0) exp_ferr++;
            else if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         base;
        logic [7:0] seq3[3];
        reset      = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        exp_ovf    = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(1);
        chk("reset_ready", {31'd0, ready}, 0);
        chk("reset_overflow", {31'd0, overflow}, 0);
        chk("reset_frame_err", {31'd0, frame_err}, 0);

        // Single frame latency and content
        send_frame(8'h1C, 0, 11, 1'b0, lat);
        chk("latency_in_bound", {31'd0, (lat >= 1 && lat <= S + 2)}, 1);
        chk("single_data", {24'd0, data}, 32'h1C);
        chk("single_frame_err_cnt", ferr_seen, exp_ferr);
        pop_n(1);
        chk("single_ready_after_pop", {31'd0, ready}, 0);

        // Ordered multi-byte
        seq3 = '{8'hE0, 8'hF0, 8'h75};
        foreach (seq3[i]) send_frame(seq3[i], 0, 11, 1'b0, lat);
        base = pops_seen;
        pop_n(3);
        chk("multi_pop_count", pops_seen - base, 3);
        chk("multi_last", {24'd0, last_pop}, 32'h75);
        chk("multi_ready_empty", {31'd0, ready}, 0);

        // Parity error then recovery
        send_frame(8'h29, 1, 11, 1'b0, lat);
        chk("parity_frame_err_cnt", ferr_seen, exp_ferr);
        chk("parity_ready", {31'd0, ready}, 0);
        send_frame(8'h29, 0, 11, 1'b0, lat);
        chk("parity_recover_data", {24'd0, data}, 32'h29);
        pop_n(1);

        // Overflow
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 1'b0, lat);
        chk("ovf_flag", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("ovf_head", {24'd0, data}, 32'h01);
        pop_n(8);
        chk("ovf_last", {24'd0, last_pop}, 32'h08);
        chk("ovf_drained", {31'd0, ready}, 0);
        do_reset();
        chk("ovf_reset_flag", {31'd0, overflow}, 0);
        chk("ovf_reset_ready", {31'd0, ready}, 0);

        // Push and pop in the same cycle while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 0, 11, 1'b0, lat);
        send_frame(8'h5A, 0, 11, 1'b1, lat);
        chk("full_concurrent_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        base = pops_seen;
        pop_n(DEPTH + 1);
        chk("full_concurrent_count", pops_seen - base, DEPTH);
        chk("full_concurrent_last", {24'd0, last_pop}, 32'h5A);

        // Reset in the middle of a frame
        send_frame(8'h1C, 0, 5, 1'b0, lat);
        do_reset();
        send_frame(8'h1C, 0, 11, 1'b0, lat);
        chk("midreset_frame_err_cnt", ferr_seen, exp_ferr);
        pop_n(1);
        chk("midreset_data", {24'd0, last_pop}, 32'h1C);

`ifdef PS2_RX_TIMEOUT_EN
        send_frame(8'h1C, 0, 5, 1'b0, lat);
        tick(TO + 20);
        exp_ferr++;
        chk("timeout_frame_err_cnt", ferr_seen, exp_ferr);
        send_frame(8'h1C, 0, 11, 1'b0, lat);
        pop_n(1);
        chk("timeout_recover_data", {24'd0, last_pop}, 32'h1C);
`endif

        // Randomised mix of good and bad frames with interleaved pops
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(8'($urandom), kind, 11, 1'b0, lat);
            chk("rand_frame_err_cnt", ferr_seen, exp_ferr);
            chk("rand_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            pop_n($urandom_range(0, 2));
        end
        pop_n(DEPTH);
        chk("rand_final_ready", {31'd0, ready}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
